mem_burst_seq: RTL

- Command-driven Avalon-MM master sequencer for the memory checker.
- Turns one test command (write or read-check, byte address, byte length, pattern seed) into one Avalon-MM burst.
- Generates first/last-beat byteenable masks from the byte offsets.
- Writes pattern data, or reads back and compares enabled lanes against the same pattern.
- Sits between the checker's control CSR logic and the memory-side Avalon-MM port.

---
 rtl/mem_burst_seq.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_burst_seq.sv
`default_nettype none
// ============================================================================
// mem_burst_seq : turns one write / read-check command into one Avalon-MM
// burst with pattern data. Optional read watchdog: MEM_BURST_SEQ_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module mem_burst_seq #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 28,
    parameter int BURST_W     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 cmd_valid_i,
    output logic                                 cmd_ready_o,
    input  logic                                 cmd_op_i,
    input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]   cmd_addr_i,
    input  logic [15:0]                          cmd_len_i,
    input  logic [31:0]                          cmd_pattern_i,
    output logic                                 done_o,
    output logic                                 cmd_err_o,
    output logic [15:0]                          err_cnt_o,
    output logic [ADDR_W-1:0]                    first_err_addr_o,
    output logic                                 timeout_o,
    output logic [ADDR_W-1:0]                    avm_address_o,
    output logic                                 avm_write_o,
    output logic                                 avm_read_o,
    output logic [DATA_W-1:0]                    avm_writedata_o,
    output logic [DATA_W/8-1:0]                  avm_byteenable_o,
    output logic [BURST_W-1:0]                   avm_burstcount_o,
    input  logic                                 avm_waitrequest_i,
    input  logic [DATA_W-1:0]                    avm_readdata_i,
    input  logic                                 avm_readdatavalid_i
);

    localparam int BE_W      = DATA_W / 8;
    localparam int OFF_W     = $clog2(BE_W);
    localparam int LANES     = DATA_W / 32;
    localparam int MAX_WORDS = 1 << (BURST_W - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    base_q;
    logic [BURST_W-1:0]   words_q;
    logic [OFF_W-1:0]     so_q;
    logic [OFF_W-1:0]     eo_q;
    logic [31:0]          pat_q;
    logic [BURST_W-1:0]   beat_q;
    logic [BURST_W-1:0]   rcv_q;
    logic [ADDR_W-1:0]    avm_address_q;
    logic                 avm_write_q;
    logic                 avm_read_q;
    logic [DATA_W-1:0]    avm_writedata_q;
    logic [BE_W-1:0]      avm_byteenable_q;
    logic [BURST_W-1:0]   avm_burstcount_q;
    logic                 done_q;
    logic                 cmd_err_q;
    logic [15:0]          err_cnt_q;
    logic [ADDR_W-1:0]    first_err_q;

    // Byte-offset arithmetic: span is the offset of the last byte from the
    // start of the first word, so it needs one bit more than the length.
    logic [OFF_W-1:0]     cmd_so;
    logic [16:0]          cmd_span;
    logic [16:0]          cmd_words;
    logic                 cmd_bad;

    assign cmd_so    = cmd_addr_i[OFF_W-1:0];
    assign cmd_span  = 17'(cmd_so) + 17'(cmd_len_i) - 17'd1;
    assign cmd_words = (cmd_span >> OFF_W) + 17'd1;
    assign cmd_bad   = (cmd_len_i == 16'd0) || (cmd_words > 17'(MAX_WORDS));

    function automatic logic [BE_W-1:0] beat_mask(
        input logic [BURST_W-1:0] idx,
        input logic [BURST_W-1:0] nwords,
        input logic [OFF_W-1:0]   so,
        input logic [OFF_W-1:0]   eo
    );
        logic [BE_W-1:0] m;
        m = '1;
        if (idx == '0)
            m = m & ({BE_W{1'b1}} << so);
        if (idx == nwords - BURST_W'(1))
            m = m & ({BE_W{1'b1}} >> (OFF_W'(BE_W - 1) - eo));
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] beat_data(
        input logic [31:0]        pat,
        input logic [BURST_W-1:0] idx
    );
        return {LANES{pat + 32'(idx)}};
    endfunction

    logic [BURST_W-1:0]   wr_next;
    logic                 wr_last;
    logic                 rd_take;
    logic [BURST_W-1:0]   rd_cnt_d;
    logic [BE_W-1:0]      rd_be;
    logic [DATA_W-1:0]    rd_bitmask;
    logic                 rd_mismatch;

    assign wr_next  = beat_q + BURST_W'(1);
    assign wr_last  = (beat_q == words_q - BURST_W'(1));
    assign rd_take  = avm_readdatavalid_i &&
                      ((state_q == S_RD_REQ) || (state_q == S_RD_WAIT));
    assign rd_cnt_d = rcv_q + BURST_W'(rd_take);
    assign rd_be    = beat_mask(rcv_q, words_q, so_q, eo_q);

    for (genvar i = 0; i < BE_W; i++) begin : g_be_expand
        assign rd_bitmask[8*i +: 8] = {8{rd_be[i]}};
    end

    assign rd_mismatch = |((avm_readdata_i ^ beat_data(pat_q, rcv_q)) & rd_bitmask);

`ifdef MEM_BURST_SEQ_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDOG_W-1:0]    wdog_q;
    logic                 timeout_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            words_q          <= '0;
            so_q             <= '0;
            eo_q             <= '0;
            pat_q            <= '0;
            beat_q           <= '0;
            rcv_q            <= '0;
            avm_address_q    <= '0;
            avm_write_q      <= 1'b0;
            avm_read_q       <= 1'b0;
            avm_writedata_q  <= '0;
            avm_byteenable_q <= '0;
            avm_burstcount_q <= '0;
            done_q           <= 1'b0;
            cmd_err_q        <= 1'b0;
            err_cnt_q        <= '0;
            first_err_q      <= '0;
`ifdef MEM_BURST_SEQ_TIMEOUT_EN
            wdog_q           <= '0;
            timeout_q        <= 1'b0;
`endif
        end else begin
            done_q    <= 1'b0;
            cmd_err_q <= 1'b0;

            // A zero error count doubles as "no mismatch seen since reset".
            if (rd_take) begin
                rcv_q <= rd_cnt_d;
                if (rd_mismatch) begin
                    if (err_cnt_q != 16'hFFFF)
                        err_cnt_q <= err_cnt_q + 16'd1;
                    if (err_cnt_q == 16'd0)
                        first_err_q <= base_q + ADDR_W'(rcv_q);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        if (cmd_bad) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            base_q           <= cmd_addr_i[ADDR_W+OFF_W-1:OFF_W];
                            words_q          <= BURST_W'(cmd_words);
                            so_q             <= cmd_so;
                            eo_q             <= cmd_span[OFF_W-1:0];
                            pat_q            <= cmd_pattern_i;
                            beat_q           <= '0;
                            rcv_q            <= '0;
                            avm_address_q    <= cmd_addr_i[ADDR_W+OFF_W-1:OFF_W];
                            avm_burstcount_q <= BURST_W'(cmd_words);
                            if (cmd_op_i) begin
                                // Read bursts request whole words; lane masking
                                // is applied on the compare side.
                                avm_read_q       <= 1'b1;
                                avm_byteenable_q <= '1;
                                state_q          <= S_RD_REQ;
                            end else begin
                                avm_write_q      <= 1'b1;
                                avm_writedata_q  <= beat_data(cmd_pattern_i, '0);
                                avm_byteenable_q <= beat_mask('0, BURST_W'(cmd_words),
                                                              cmd_so, cmd_span[OFF_W-1:0]);
                                state_q          <= S_WR;
                            end
                        end
                    end
                end

                S_WR: begin
                    if (!avm_waitrequest_i) begin
                        if (wr_last) begin
                            avm_write_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            beat_q           <= wr_next;
                            avm_writedata_q  <= beat_data(pat_q, wr_next);
                            avm_byteenable_q <= beat_mask(wr_next, words_q, so_q, eo_q);
                        end
                    end
                end

                S_RD_REQ: begin
                    if (!avm_waitrequest_i) begin
                        avm_read_q <= 1'b0;
                        state_q    <= S_RD_WAIT;
`ifdef MEM_BURST_SEQ_TIMEOUT_EN
                        wdog_q     <= '0;
`endif
                    end
                end

                S_RD_WAIT: begin
                    if (rd_cnt_d == words_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
`ifdef MEM_BURST_SEQ_TIMEOUT_EN
                    else if (rd_take) begin
                        wdog_q <= '0;
                    end else if (wdog_q == WDOG_W'(TIMEOUT_CYC - 1)) begin
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + WDOG_W'(1);
                    end
`endif
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o      = (state_q == S_IDLE);
    assign done_o           = done_q;
    assign cmd_err_o        = cmd_err_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_err_q;
    assign avm_address_o    = avm_address_q;
    assign avm_write_o      = avm_write_q;
    assign avm_read_o       = avm_read_q;
    assign avm_writedata_o  = avm_writedata_q;
    assign avm_byteenable_o = avm_byteenable_q;
    assign avm_burstcount_o = avm_burstcount_q;

`ifdef MEM_BURST_SEQ_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire
